// File: rtl/run_counter.sv
// run_counter: programmable-length run counter with stall, abort,
// continuous restart, completed-run counter and illegal-length rejection.
module run_counter #(
  parameter  int unsigned MAX_COUNT = 16,
  parameter  int unsigned ITER_W    = 8,
  localparam int unsigned CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic              mode_i,
  input  logic              en_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              last_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ITER_W-1:0] iter_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_len;
  logic                r_mode;
  logic [ITER_W-1:0]   r_iter;
  logic                r_err;
  logic                r_busy;
  logic                r_done;
  logic                r_last;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0]    w_len_nxt;
  logic                w_mode_nxt;
  logic [ITER_W-1:0]   w_iter_nxt;
  logic                w_err_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_last_nxt;
  logic                w_len_legal;
  logic                w_at_last;

  // Legal length window and end-of-run detect on the latched length
  always_comb begin
    w_len_legal = (len_i != '0) && (len_i <= CNT_W'(MAX_COUNT));
    w_at_last   = (r_cnt == (r_len - CNT_W'(1)));
  end

  // Next-state, datapath and registered-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_mode_nxt  = r_mode;
    w_iter_nxt  = r_iter;
    w_err_nxt   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (start_i) begin
          if (w_len_legal) begin
            w_len_nxt   = len_i;
            w_mode_nxt  = mode_i;
            w_iter_nxt  = '0;
            w_state_nxt = S_RUN;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_RUN: begin
        // Abort wins over completion
        if (abort_i) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (en_i) begin
          if (w_at_last) begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = '0;
            w_iter_nxt  = r_iter + ITER_W'(1);
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        w_cnt_nxt = '0;
        if (abort_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_mode) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
    w_last_nxt = (w_state_nxt == S_RUN) && (w_cnt_nxt == (w_len_nxt - CNT_W'(1)));
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_mode  <= 1'b0;
      r_iter  <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_mode  <= w_mode_nxt;
      r_iter  <= w_iter_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign busy_o = r_busy;
  assign cnt_o  = r_cnt;
  assign last_o = r_last;
  assign done_o = r_done;
  assign err_o  = r_err;
  assign iter_o = r_iter;

endmodule

// File: tb/tb_run_counter.sv
// Directed bench for run_counter: each step queues the expected outputs
// for the coming edge, then pops and compares them after that edge.
module tb_run_counter;

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned ITER_W = 8;
  localparam int unsigned VEC_W  = 1 + CNT_W + 1 + 1 + 1 + ITER_W;

  typedef struct {
    logic [VEC_W-1:0] vec;
    string            tag;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic [CNT_W-1:0]  len_i;
  logic              mode_i;
  logic              en_i;
  logic              abort_i;
  logic              busy_o;
  logic [CNT_W-1:0]  cnt_o;
  logic              last_o;
  logic              done_o;
  logic              err_o;
  logic [ITER_W-1:0] iter_o;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  run_counter #(.MAX_COUNT(16), .ITER_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start_i(start_i),
    .len_i  (len_i),
    .mode_i (mode_i),
    .en_i   (en_i),
    .abort_i(abort_i),
    .busy_o (busy_o),
    .cnt_o  (cnt_o),
    .last_o (last_o),
    .done_o (done_o),
    .err_o  (err_o),
    .iter_o (iter_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Queue expectation, advance one edge, pop and compare
  task automatic step(input string tag, input logic busy, input int cnt,
                      input logic last, input logic done, input logic err,
                      input int iter);
    exp_t e;
    exp_t p;
    logic [VEC_W-1:0] got;
    e.vec = {busy, CNT_W'(cnt), last, done, err, ITER_W'(iter)};
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    p = exp_q.pop_front();
    got = {busy_o, cnt_o, last_o, done_o, err_o, iter_o};
    checks++;
    assert (got === p.vec) else begin
      errors++;
      $error("FAIL %s got busy/cnt/last/done/err/iter=%b/%0d/%b/%b/%b/%0d exp=%b/%0d/%b/%b/%b/%0d",
             p.tag, got[VEC_W-1], got[VEC_W-2 -: CNT_W], got[ITER_W+2], got[ITER_W+1],
             got[ITER_W], got[ITER_W-1:0], p.vec[VEC_W-1], p.vec[VEC_W-2 -: CNT_W],
             p.vec[ITER_W+2], p.vec[ITER_W+1], p.vec[ITER_W], p.vec[ITER_W-1:0]);
    end
  endtask

  task automatic do_start(input int len, input logic mode);
    start_i = 1'b1;
    len_i   = CNT_W'(len);
    mode_i  = mode;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; len_i = '0; mode_i = 1'b0; en_i = 1'b1; abort_i = 1'b0;
    #1;
    // Reset
    step("rst0", 0, 0, 0, 0, 0, 0);
    step("rst1", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step("idle", 0, 0, 0, 0, 0, 0);

    // Single run, len=4
    do_start(4, 1'b0);
    step("r4_c0", 1, 0, 0, 0, 0, 0);
    start_i = 1'b0;
    step("r4_c1", 1, 1, 0, 0, 0, 0);
    step("r4_c2", 1, 2, 0, 0, 0, 0);
    step("r4_c3", 1, 3, 1, 0, 0, 0);
    step("r4_done", 1, 0, 0, 1, 0, 1);
    step("r4_idle", 0, 0, 0, 0, 0, 1);

    // Stall, len=3
    do_start(3, 1'b0);
    step("st_c0", 1, 0, 0, 0, 0, 0);
    start_i = 1'b0;
    step("st_c1", 1, 1, 0, 0, 0, 0);
    en_i = 1'b0;
    step("st_hold0", 1, 1, 0, 0, 0, 0);
    step("st_hold1", 1, 1, 0, 0, 0, 0);
    en_i = 1'b1;
    step("st_c2", 1, 2, 1, 0, 0, 0);
    step("st_done", 1, 0, 0, 1, 0, 1);
    step("st_idle", 0, 0, 0, 0, 0, 1);

    // Illegal lengths: 0 and MAX_COUNT+1
    do_start(0, 1'b1);
    step("err_len0", 0, 0, 0, 0, 1, 1);
    start_i = 1'b0;
    step("err_len0_clr", 0, 0, 0, 0, 0, 1);
    do_start(17, 1'b1);
    step("err_len17", 0, 0, 0, 0, 1, 1);
    start_i = 1'b0;
    step("err_len17_clr", 0, 0, 0, 0, 0, 1);

    // Largest legal length
    do_start(16, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step($sformatf("max_c%0d", i), 1, i, (i == 15), 0, 0, 0);
      start_i = 1'b0;
    end
    step("max_done", 1, 0, 0, 1, 0, 1);
    step("max_idle", 0, 0, 0, 0, 0, 1);

    // Continuous mode, len=2; en low during DONE must not stall
    do_start(2, 1'b1);
    step("ct_c0a", 1, 0, 0, 0, 0, 0);
    start_i = 1'b0;
    step("ct_c1a", 1, 1, 1, 0, 0, 0);
    step("ct_done1", 1, 0, 0, 1, 0, 1);
    en_i = 1'b0;
    step("ct_c0b", 1, 0, 0, 0, 0, 1);
    en_i = 1'b1;
    step("ct_c1b", 1, 1, 1, 0, 0, 1);
    step("ct_done2", 1, 0, 0, 1, 0, 2);
    step("ct_c0c", 1, 0, 0, 0, 0, 2);
    step("ct_c1c", 1, 1, 1, 0, 0, 2);
    step("ct_done3", 1, 0, 0, 1, 0, 3);
    step("ct_c0d", 1, 0, 0, 0, 0, 3);
    step("ct_c1d", 1, 1, 1, 0, 0, 3);
    abort_i = 1'b1;
    step("ct_abort", 0, 0, 0, 0, 0, 3);
    abort_i = 1'b0;
    step("ct_hold", 0, 0, 0, 0, 0, 3);

    // len=5: start during RUN ignored, abort on completion cycle
    do_start(5, 1'b0);
    step("ab_c0", 1, 0, 0, 0, 0, 0);
    start_i = 1'b0;
    step("ab_c1", 1, 1, 0, 0, 0, 0);
    do_start(2, 1'b1);
    step("ab_ign", 1, 2, 0, 0, 0, 0);
    start_i = 1'b0;
    step("ab_c3", 1, 3, 0, 0, 0, 0);
    step("ab_c4", 1, 4, 1, 0, 0, 0);
    abort_i = 1'b1;
    step("ab_last", 0, 0, 0, 0, 0, 0);
    step("ab_idle_abort", 0, 0, 0, 0, 0, 0);

    // len=1 with abort also high in IDLE: start honoured
    do_start(1, 1'b0);
    step("l1_run", 1, 0, 1, 0, 0, 0);
    start_i = 1'b0;
    abort_i = 1'b0;
    step("l1_done", 1, 0, 0, 1, 0, 1);
    step("l1_idle", 0, 0, 0, 0, 0, 1);

    // Mid-run reset, len=6 continuous
    do_start(6, 1'b1);
    step("mr_c0", 1, 0, 0, 0, 0, 0);
    start_i = 1'b0;
    step("mr_c1", 1, 1, 0, 0, 0, 0);
    step("mr_c2", 1, 2, 0, 0, 0, 0);
    rst = 1'b1;
    step("mr_rst", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step("mr_idle", 0, 0, 0, 0, 0, 0);
    do_start(2, 1'b0);
    step("pr_c0", 1, 0, 0, 0, 0, 0);
    start_i = 1'b0;
    step("pr_c1", 1, 1, 1, 0, 0, 0);
    step("pr_done", 1, 0, 0, 1, 0, 1);
    step("pr_idle", 0, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
